serial_write_buffer: RTL and testbench

//   Parallel-to-serial transmit buffer; the transmit-side counterpart of the serial read buffer.

---
 rtl/serial_write_buffer_if.sv | 26 ++
 rtl/serial_write_buffer.sv | 74 +++++++
 tb/tb_serial_write_buffer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serial_write_buffer_if.sv
// Handshake and data signals between a word producer and the serial write buffer.
interface serial_write_buffer_if #(
   parameter int unsigned BUF_SIZE = 8
);
   logic                start;
   logic                write_sig;
   logic [BUF_SIZE-1:0] data_in;
   logic                data_out;
   logic                done_sig;

   modport master (
      output start,
      output write_sig,
      output data_in,
      input  data_out,
      input  done_sig
   );

   modport slave (
      input  start,
      input  write_sig,
      input  data_in,
      output data_out,
      output done_sig
   );
endinterface

// File: rtl/serial_write_buffer.sv
// Parallel-to-serial transmit buffer: latches a word on start and presents it MSB first,
// advancing one bit per write_sig strobe.
module serial_write_buffer #(
   parameter int unsigned BUF_SIZE   = 8,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input logic                  sys_clk,
   input logic                  rst,
   serial_write_buffer_if.slave bus
);
   localparam int unsigned CntW = $clog2(BUF_SIZE);
   localparam logic [CntW-1:0] LastCnt = CntW'(BUF_SIZE - 1);

   typedef enum logic {StIdle, StShift} state_e;

   state_e              state_q, state_d;
   logic [BUF_SIZE-1:0] shreg_q, shreg_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                data_out_q, data_out_d;
   logic                done_q, done_d;

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      data_out_d = data_out_q;
      done_d     = done_q;
      unique case (state_q)
         StIdle: begin
            // A strobe coinciding with start is dropped so the MSB is still presented.
            if (bus.start) begin
               state_d    = StShift;
               shreg_d    = bus.data_in;
               data_out_d = bus.data_in[BUF_SIZE-1];
               cnt_d      = '0;
               done_d     = 1'b0;
            end
         end
         StShift: begin
            if (bus.write_sig) begin
               if (cnt_q == LastCnt) begin
                  state_d    = StIdle;
                  data_out_d = IDLE_LEVEL;
                  done_d     = 1'b1;
               end else begin
                  cnt_d      = cnt_q + CntW'(1);
                  data_out_d = shreg_q[BUF_SIZE-2];
                  shreg_d    = {shreg_q[BUF_SIZE-2:0], 1'b0};
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         shreg_q    <= '0;
         cnt_q      <= '0;
         data_out_q <= IDLE_LEVEL;
         done_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         data_out_q <= data_out_d;
         done_q     <= done_d;
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.done_sig = done_q;
endmodule

// File: tb/tb_serial_write_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a word/pulse-count model.
module tb_serial_write_buffer;
   logic sys_clk = 1'b0;
   logic rst     = 1'b0;
   logic checking = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 sys_clk = ~sys_clk;

   serial_write_buffer_if #(.BUF_SIZE(8)) bus8 ();
   serial_write_buffer_if #(.BUF_SIZE(4)) bus4 ();

   serial_write_buffer #(.BUF_SIZE(8), .IDLE_LEVEL(1'b0)) dut8 (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus8.slave)
   );

   serial_write_buffer #(.BUF_SIZE(4), .IDLE_LEVEL(1'b1)) dut4 (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus4.slave)
   );

   // Model: a word is in flight while busy; after p strobes it shows bit W-1-p.
   logic       m8_busy = 1'b0, m4_busy = 1'b0;
   logic [7:0] m8_word = '0;
   logic [3:0] m4_word = '0;
   int         m8_pulses = 0, m4_pulses = 0;

   always @(posedge sys_clk) begin
      if (!rst) begin
         m8_busy <= 1'b0;
         m4_busy <= 1'b0;
      end else begin
         if (!m8_busy) begin
            if (bus8.start) begin
               m8_busy <= 1'b1; m8_word <= bus8.data_in; m8_pulses <= 0;
            end
         end else if (bus8.write_sig) begin
            m8_pulses <= m8_pulses + 1;
            if (m8_pulses + 1 == 8) m8_busy <= 1'b0;
         end
         if (!m4_busy) begin
            if (bus4.start) begin
               m4_busy <= 1'b1; m4_word <= bus4.data_in; m4_pulses <= 0;
            end
         end else if (bus4.write_sig) begin
            m4_pulses <= m4_pulses + 1;
            if (m4_pulses + 1 == 4) m4_busy <= 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge sys_clk) begin
      if (checking) begin
         check("model8 data_out", 32'(bus8.data_out),
               32'(m8_busy ? m8_word[7 - m8_pulses] : 1'b0));
         check("model8 done_sig", 32'(bus8.done_sig), 32'(!m8_busy));
         check("model4 data_out", 32'(bus4.data_out),
               32'(m4_busy ? m4_word[3 - m4_pulses] : 1'b1));
         check("model4 done_sig", 32'(bus4.done_sig), 32'(!m4_busy));
      end
   end

   task automatic tick();
      @(negedge sys_clk);
   endtask

   task automatic strobe8();
      bus8.write_sig = 1'b1; tick(); bus8.write_sig = 1'b0;
   endtask

   // Start a word, then sample the line before each of 8 strobes spaced gap cycles apart.
   task automatic send8(input logic [7:0] w, input int gap, output logic [7:0] got);
      bus8.start = 1'b1; bus8.data_in = w; tick();
      bus8.start = 1'b0; bus8.data_in = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         for (int g = 1; g < gap; g++) tick();
         got[7-i] = bus8.data_out;
         check("busy before strobe", 32'(bus8.done_sig), 32'h0);
         strobe8();
      end
      check("done after last strobe", 32'(bus8.done_sig), 32'h1);
      check("idle level after word", 32'(bus8.data_out), 32'h0);
   endtask

   logic [7:0] got;
   logic [3:0] got4;

   initial begin
      bus8.start = 1'b0; bus8.write_sig = 1'b0; bus8.data_in = '0;
      bus4.start = 1'b0; bus4.write_sig = 1'b0; bus4.data_in = '0;
      tick(); tick();
      rst = 1'b1;
      checking = 1'b1;
      check("reset data_out", 32'(bus8.data_out), 32'h0);
      check("reset done_sig", 32'(bus8.done_sig), 32'h1);
      repeat (3) begin strobe8(); tick(); end
      check("idle strobes data_out", 32'(bus8.data_out), 32'h0);
      check("idle strobes done_sig", 32'(bus8.done_sig), 32'h1);

      send8(8'h3a, 8, got);
      check("stream 3a", 32'(got), 32'h3a);

      send8(8'h71, 3, got);
      check("stream 71", 32'(got), 32'h71);
      send8(8'hf0, 2, got);
      check("stream f0 back-to-back", 32'(got), 32'hf0);

      bus8.start = 1'b1; bus8.data_in = 8'hff; tick(); bus8.start = 1'b0;
      repeat (3) strobe8();
      rst = 1'b0; tick(); rst = 1'b1;
      check("abort data_out", 32'(bus8.data_out), 32'h0);
      check("abort done_sig", 32'(bus8.done_sig), 32'h1);
      repeat (2) strobe8();
      check("post-abort strobes", 32'(bus8.data_out), 32'h0);
      send8(8'h81, 1, got);
      check("stream 81", 32'(got), 32'h81);

      bus8.start = 1'b1; bus8.write_sig = 1'b1; bus8.data_in = 8'h80; tick();
      bus8.start = 1'b0; bus8.write_sig = 1'b0;
      check("start+strobe MSB", 32'(bus8.data_out), 32'h1);
      got[7] = bus8.data_out;
      strobe8();
      bus8.start = 1'b1; bus8.data_in = 8'h00; tick(); bus8.start = 1'b0;
      for (int i = 1; i < 8; i++) begin
         got[7-i] = bus8.data_out;
         strobe8();
      end
      check("start in shift ignored", 32'(got), 32'h80);

      bus4.start = 1'b1; bus4.data_in = 4'h5; tick(); bus4.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         got4[3-i] = bus4.data_out;
         bus4.write_sig = 1'b1; tick(); bus4.write_sig = 1'b0;
      end
      check("stream4 5", 32'(got4), 32'h5);
      check("idle4 level", 32'(bus4.data_out), 32'h1);
      check("idle4 done", 32'(bus4.done_sig), 32'h1);

      for (int c = 0; c < 3000; c++) begin
         bus8.start     = ($urandom_range(0, 15) == 0);
         bus8.write_sig = ($urandom_range(0, 2) == 0);
         bus8.data_in   = 8'($urandom);
         bus4.start     = ($urandom_range(0, 7) == 0);
         bus4.write_sig = ($urandom_range(0, 3) == 0);
         bus4.data_in   = 4'($urandom);
         rst            = ($urandom_range(0, 199) != 0);
         tick();
      end
      rst = 1'b1;
      bus8.start = 1'b0; bus8.write_sig = 1'b0;
      bus4.start = 1'b0; bus4.write_sig = 1'b0;
      tick();
      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
